// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset level, bus widths,
// FSM state encodings and the default instruction-cache size.
package if_stage_pkg;

  localparam logic        RstEnable        = 1'b1;
  localparam int          InstAddrBus      = 32;
  localparam int          InstBus          = 32;
  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam int          ICACHE_LINES_DEF = 32;

  typedef enum logic [1:0] {
    IF_S_FETCH = 2'b00,
    IF_S_WAIT  = 2'b01,
    IF_S_OUT   = 2'b10
  } if_state_e;

  function automatic logic [InstAddrBus-1:0] next_word_pc(input logic [InstAddrBus-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache with one-word lines: combinational lookup,
// synchronous fill, valid bits cleared by rst. Used only when ICACHE_EN is defined.
module if_icache
  import if_stage_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [29:0]         lookup_word,
  output logic                hit,
  output logic [InstBus-1:0]  data,
  input  logic                fill_en,
  input  logic [29:0]         fill_word,
  input  logic [InstBus-1:0]  fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [LINES-1:0]   valid_r;
  logic [TAG_W-1:0]   tag_r  [LINES];
  logic [InstBus-1:0] data_r [LINES];

  logic [IDX_W-1:0] lookup_idx_s;
  logic [TAG_W-1:0] lookup_tag_s;
  logic [IDX_W-1:0] fill_idx_s;
  logic [TAG_W-1:0] fill_tag_s;

  assign lookup_idx_s = lookup_word[IDX_W-1:0];
  assign lookup_tag_s = lookup_word[29:IDX_W];
  assign fill_idx_s   = fill_word[IDX_W-1:0];
  assign fill_tag_s   = fill_word[29:IDX_W];

  // Hit detection and data read for the current PC
  always_comb begin
    hit  = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
    data = data_r[lookup_idx_s];
  end

  // Valid bits: cleared on reset, set on fill
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[fill_idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data storage, no reset needed behind the valid bits
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= fill_data;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: assembles each word from four byte reads and hands it
// to IF/ID with a valid/stall handshake. Define ICACHE_EN to add the instruction cache.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                     ICACHE_LINES = ICACHE_LINES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_addr_i,
  input  logic                   mem_busy_i,
  input  logic [7:0]             mem_byte_i,
  output logic                   if_req_o,
  output logic [InstAddrBus-1:0] if_addr_o,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   inst_valid_o
);

  if_state_e              state_r, state_s;
  logic [InstAddrBus-1:0] pc_r;
  logic [1:0]             cnt_r;
  logic [23:0]            buf_r;
  logic                   rd_pend_r;
  logic [1:0]             rd_lane_r;
  logic [InstAddrBus-1:0] pc_out_r;
  logic [InstBus-1:0]     inst_out_r;
  logic                   valid_out_r;
  logic                   issue_s;
  logic                   hit_s;
  logic [InstBus-1:0]     hit_data_s;

`ifdef ICACHE_EN
  logic               lookup_hit_s;
  logic [InstBus-1:0] lookup_data_s;
  logic               fill_en_s;

  // A redirect in S_WAIT discards the word, so it must not be filled either
  assign fill_en_s  = (state_r == IF_S_WAIT) && !branch_flag_i;
  assign hit_s      = lookup_hit_s && (state_r == IF_S_FETCH) && (cnt_r == 2'd0) && !branch_flag_i;
  assign hit_data_s = lookup_data_s;

  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (pc_r[31:2]),
    .hit         (lookup_hit_s),
    .data        (lookup_data_s),
    .fill_en     (fill_en_s),
    .fill_word   (pc_r[31:2]),
    .fill_data   ({mem_byte_i, buf_r})
  );
`else
  localparam int unused_lines_p = ICACHE_LINES;
  assign hit_s      = 1'b0;
  assign hit_data_s = ZeroWord;
`endif

  assign issue_s = (rst != RstEnable) && (state_r == IF_S_FETCH) && !mem_busy_i
                   && !branch_flag_i && !hit_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_r <= IF_S_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; redirect overrides every state
  always_comb begin
    state_s = state_r;
    if (branch_flag_i) begin
      state_s = IF_S_FETCH;
    end else begin
      case (state_r)
        IF_S_FETCH: begin
          if (hit_s)                          state_s = IF_S_OUT;
          else if (issue_s && cnt_r == 2'd3)  state_s = IF_S_WAIT;
          else                                state_s = IF_S_FETCH;
        end
        IF_S_WAIT: state_s = IF_S_OUT;
        IF_S_OUT: begin
          if (stall_i) state_s = IF_S_OUT;
          else         state_s = IF_S_FETCH;
        end
        default: state_s = IF_S_FETCH;
      endcase
    end
  end

  // FSM outputs: memory request and address
  always_comb begin
    if_req_o  = 1'b0;
    if_addr_o = ZeroWord;
    if (rst == RstEnable) begin
      if_req_o  = 1'b0;
      if_addr_o = ZeroWord;
    end else begin
      if_req_o  = issue_s;
      if_addr_o = pc_r + {30'd0, cnt_r};
    end
  end

  // PC, byte counter, byte assembly and registered IF/ID outputs
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_r        <= RESET_PC;
      cnt_r       <= 2'd0;
      buf_r       <= 24'd0;
      rd_pend_r   <= 1'b0;
      rd_lane_r   <= 2'd0;
      pc_out_r    <= ZeroWord;
      inst_out_r  <= ZeroWord;
      valid_out_r <= 1'b0;
    end else begin
      rd_pend_r <= issue_s;
      rd_lane_r <= cnt_r;
      // Lane 3 is taken straight from the bus in S_WAIT
      if (rd_pend_r) begin
        case (rd_lane_r)
          2'd0:    buf_r[7:0]   <= mem_byte_i;
          2'd1:    buf_r[15:8]  <= mem_byte_i;
          2'd2:    buf_r[23:16] <= mem_byte_i;
          default: buf_r        <= buf_r;
        endcase
      end else begin
        buf_r <= buf_r;
      end
      if (branch_flag_i) begin
        pc_r        <= branch_target_addr_i;
        cnt_r       <= 2'd0;
        valid_out_r <= 1'b0;
      end else begin
        case (state_r)
          IF_S_FETCH: begin
            if (hit_s) begin
              inst_out_r  <= hit_data_s;
              pc_out_r    <= pc_r;
              valid_out_r <= 1'b1;
            end else if (issue_s) begin
              cnt_r <= cnt_r + 2'd1;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          IF_S_WAIT: begin
            inst_out_r  <= {mem_byte_i, buf_r};
            pc_out_r    <= pc_r;
            valid_out_r <= 1'b1;
          end
          IF_S_OUT: begin
            if (!stall_i) begin
              valid_out_r <= 1'b0;
              pc_r        <= next_word_pc(pc_r);
              cnt_r       <= 2'd0;
            end else begin
              valid_out_r <= valid_out_r;
            end
          end
          default: cnt_r <= 2'd0;
        endcase
      end
    end
  end

  assign pc_o         = pc_out_r;
  assign inst_o       = inst_out_r;
  assign inst_valid_o = valid_out_r;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: random memory image, random busy/stall
// patterns, and directed redirect/reset/wrap scenarios (cache hit with ICACHE_EN).
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic        mem_busy_i;
  logic [7:0]  mem_byte_i;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  logic [7:0] mem [0:4095];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_busy_i           (mem_busy_i),
    .mem_byte_i           (mem_byte_i),
    .if_req_o             (if_req_o),
    .if_addr_o            (if_addr_o),
    .pc_o                 (pc_o),
    .inst_o               (inst_o),
    .inst_valid_o         (inst_valid_o)
  );

  // Memory controller: requested byte one cycle later, garbage otherwise
  always @(posedge clk) begin
    if (if_req_o) mem_byte_i <= mem[if_addr_o[11:0]];
    else          mem_byte_i <= 8'($urandom);
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [11:0] a;
    a = pc[11:0];
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue n bytes of the word at pc with no busy cycles; returns at a negedge
  task automatic partial(input logic [31:0] pc, input int n);
    mem_busy_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("part_req", {31'd0, if_req_o}, 32'd1);
      chk("part_addr", if_addr_o, pc + 32'(k));
      chk("part_valid", {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk);
    end
  endtask

  // One full fetch at pc from S_FETCH through hand-off, busy/stall shaped by arguments
  task automatic fetch_one(input logic [31:0] pc, input logic [15:0] busy_pat, input int stall_n);
    int k;
    int i;
    k = 0;
    i = 0;
    while (k < 4 && i < 24) begin
      mem_busy_i = (i < 16) ? busy_pat[i] : 1'b0;
      #1;
      chk("fetch_valid", {31'd0, inst_valid_o}, 32'd0);
      if (mem_busy_i) begin
        chk("busy_req", {31'd0, if_req_o}, 32'd0);
      end else begin
        chk("req", {31'd0, if_req_o}, 32'd1);
        chk("addr", if_addr_o, pc + 32'(k));
        k++;
      end
      i++;
      @(negedge clk);
    end
    if (k < 4) chk("fetch_timeout", 32'(k), 32'd4);
    mem_busy_i = 1'($urandom_range(0, 1));
    #1;
    chk("wait_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("wait_req", {31'd0, if_req_o}, 32'd0);
    @(negedge clk);
    mem_busy_i = 1'b0;
    stall_i = (stall_n > 0);
    #1;
    chk("out_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("out_pc", pc_o, pc);
    chk("out_inst", inst_o, word_at(pc));
    chk("out_req", {31'd0, if_req_o}, 32'd0);
    for (int s = 1; s <= stall_n; s++) begin
      @(negedge clk);
      stall_i = (s < stall_n);
      #1;
      chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("stall_pc", pc_o, pc);
      chk("stall_inst", inst_o, word_at(pc));
      chk("stall_req", {31'd0, if_req_o}, 32'd0);
    end
    @(negedge clk);
    stall_i = 1'b0;
  endtask

  task automatic redirect_now(input logic [31:0] target);
    branch_flag_i = 1'b1;
    branch_target_addr_i = target;
    #1;
    chk("redir_req", {31'd0, if_req_o}, 32'd0);
    @(negedge clk);
    branch_flag_i = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    branch_target_addr_i = 32'd0;
    mem_busy_i = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;

    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      mem_busy_i = 1'($urandom_range(0, 1));
      #1;
      chk("rst_req", {31'd0, if_req_o}, 32'd0);
      chk("rst_addr", if_addr_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    mem_busy_i = 1'b0;

    chk("word0", word_at(32'd0), 32'h0010_0093);
    fetch_one(RST_PC, 16'h0000, 0);
    fetch_one(RST_PC + 32'd4, 16'b0000_0000_0000_0110, 0);
    fetch_one(RST_PC + 32'd8, 16'h0000, 3);
    pc = RST_PC + 32'd12;
    for (int n = 0; n < 8; n++) begin
      fetch_one(pc, 16'($urandom) & 16'h0AAB, $urandom_range(0, 3));
      pc = pc + 32'd4;
    end

    // Redirect after byte 1 issued
    partial(pc, 2);
    redirect_now(32'h0000_1000);
    fetch_one(32'h0000_1000, 16'h0000, 0);

    // Redirect in S_WAIT beats completion
    partial(32'h0000_1004, 4);
    redirect_now(32'h0000_0200);
    fetch_one(32'h0000_0200, 16'($urandom) & 16'h0055, 1);

    // Redirect while stalled in S_OUT
    partial(32'h0000_0204, 4);
    @(negedge clk);
    stall_i = 1'b1;
    #1;
    chk("pre_redir_valid", {31'd0, inst_valid_o}, 32'd1);
    redirect_now(32'hFFFF_FFFC);
    stall_i = 1'b0;
    fetch_one(32'hFFFF_FFFC, 16'h0000, 0);
    fetch_one(32'h0000_0000, 16'h0000, 0);

    // Reset during S_WAIT
    partial(32'h0000_0004, 4);
    rst = 1'b1;
    #1;
    chk("rstw_req", {31'd0, if_req_o}, 32'd0);
    chk("rstw_addr", if_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_pc", pc_o, 32'd0);
    chk("rstw_inst", inst_o, 32'd0);
    chk("rstw_valid", {31'd0, inst_valid_o}, 32'd0);
    fetch_one(RST_PC, 16'h0000, 0);

`ifdef ICACHE_EN
    // Line for RST_PC was filled above; revisit it via redirect
    redirect_now(RST_PC);
    #1;
    chk("hit_req", {31'd0, if_req_o}, 32'd0);
    chk("hit_valid0", {31'd0, inst_valid_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("hit_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("hit_pc", pc_o, RST_PC);
    chk("hit_inst", inst_o, word_at(RST_PC));
    @(negedge clk);
`endif
    partial(RST_PC + 32'd4, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline, directly upstream of the IF/ID register and the decode stage. It holds the PC and fetches each 32-bit instruction as four little-endian bytes over the shared byte-wide memory-controller port. It presents `pc_o` and `inst_o` to IF/ID with a valid/stall handshake, and redirects on the branch/jump flag returned by decode. An optional direct-mapped instruction cache short-circuits memory on hits.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `ICACHE_LINES`, default 32: cache entries, power of two. Used only with `ICACHE_EN`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset is synchronous and active-high (`RstEnable` = 1'b1).
- `stall_i` in 1: IF/ID cannot accept; hold the presented instruction.
- `branch_flag_i` in 1: redirect request from decode (combinational).
- `branch_target_addr_i` in 32: redirect PC; bits [1:0] are 0.
- `mem_busy_i` in 1: the memory controller is serving a load/store this cycle; no fetch issue is allowed.
- `mem_byte_i` in 8: read data, valid the cycle after its request.
- `if_req_o` out 1: byte read request (combinational).
- `if_addr_o` out 32: byte address (combinational).
- `pc_o` out 32: PC of the presented instruction.
- `inst_o` out 32: presented instruction.
- `inst_valid_o` out 1: `pc_o`/`inst_o` are valid for IF/ID.

## Operation
- State: `pc` (32), byte counter `cnt` (2), byte buffer (24), FSM {S_FETCH, S_WAIT, S_OUT}.
- **S_FETCH**
  - If `mem_busy_i`=0: `if_req_o`=1, `if_addr_o`=`pc`+`cnt`, `cnt`++.
  - If `mem_busy_i`=1: `if_req_o`=0 and `cnt` holds.
  - Byte k, issued in cycle c, is written into buffer lane k at the end of cycle c+1. This happens even if `mem_busy_i` is high in c+1.
  - After byte 3 is issued, go to S_WAIT.
- **S_WAIT**
  - Capture byte 3.
  - Set `inst_o`={byte3, byte2, byte1, byte0}, `pc_o`=`pc`, `inst_valid_o`=1.
  - Go to S_OUT.
- **S_OUT**
  - If `stall_i`=1: hold all outputs.
  - If `stall_i`=0: `inst_valid_o`←0, `pc`←`pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), `cnt`←0, go to S_FETCH.
- **Redirect**
  - `branch_flag_i`=1 in any state forces `if_req_o`=0 combinationally, so no stray byte is in flight.
  - At the next edge: `pc`←target, `cnt`←0, `inst_valid_o`←0, S_FETCH.
  - Redirect beats stall and beats completion in S_WAIT; the partially assembled word is discarded.
- **Reset**
  - Applies in any state, including mid-fetch: `pc`←`RESET_PC`, S_FETCH, `cnt`←0.
  - `pc_o`, `inst_o`, and `inst_valid_o` are 0.
  - `if_req_o`=0 and `if_addr_o`=0 during any cycle with `rst`=1.
  - Bytes returned after reset are ignored.

## Timing
- Miss path with no busy: first request in cycle t, `inst_valid_o` high from cycle t+5. The next fetch issues at t+6 if `stall_i`=0 at t+5. Throughput is 1 instruction per 6 cycles.
- Each busy cycle in S_FETCH adds exactly one cycle of latency.
- Redirect asserted in cycle r: the first request at the target is issued in cycle r+1.
- All outputs except `if_req_o`/`if_addr_o` are registered.

## Configuration
- `ICACHE_EN` defined:
  - Direct-mapped cache of `ICACHE_LINES` one-word lines.
  - Index = `pc`[log2(`ICACHE_LINES`)+1:2]; tag = remaining upper bits; one valid bit per line.
  - Lookup occurs in S_FETCH while `cnt`=0.
  - On a hit: `if_req_o`=0, the entry is loaded into `inst_o`, and the FSM goes directly to S_OUT. `inst_valid_o` is high in cycle t+1.
  - On a miss: normal fetch, and the line is filled on the S_WAIT→S_OUT transition.
  - `rst` clears all valid bits. A redirect during a miss fetch aborts the fill.
- `ICACHE_EN` undefined: no cache storage; every fetch goes to memory.

## Structure
- Shared defines header:
  - `RstEnable`, `ZeroWord`, `InstAddrBus`, `InstBus`.
  - New FSM state encodings `IF_S_FETCH`/`IF_S_WAIT`/`IF_S_OUT`.
  - `ICACHE_LINES` default.
- One sub-module, `if_icache`:
  - Combinational lookup (`hit`, `data`) and a synchronous fill/clear port.
  - Instantiated only under `ICACHE_EN`.

## Test plan
- Reset then release, memory bytes 0x00..0x03 = 93,00,10,00 → `if_addr_o` 0,1,2,3 in cycles 0–3; `inst_o`=32'h0010_0093, `pc_o`=0, valid at cycle 5; next `if_addr_o`=4 at cycle 6.
- `mem_busy_i` high in cycles 1–2 of the fetch at pc 0 → no request in those cycles; valid at cycle 7 with the correct word.
- `stall_i` held high for 3 cycles while valid → `pc_o`/`inst_o`/`inst_valid_o` stay constant; fetch of pc 4 starts the cycle after `stall_i` falls.
- `branch_flag_i`=1, target 32'h0000_1000, asserted after byte 1 was issued → `if_req_o`=0 that cycle; next cycle `if_addr_o`=32'h1000; no valid word for the old pc.
- `rst` asserted in S_WAIT, then released → outputs 0, first request at `RESET_PC`.
- `ICACHE_EN`: fetch pc 0 twice via a redirect to 0 → the second fetch has no `if_req_o`, and valid appears 1 cycle after redirect+1.
